mem_access_unit: RTL and testbench

- Multi-cycle load/store sequencer: the initiator side of the Data_mem read/write interface.
- Takes one memory-class instruction per `start`, computes the word address, and drives the mem_read/mem_write strobes for exactly one cycle.
- Captures read data and returns write-back, base/SP-update and return-target results to the datapath.
- Handles LW, LW_POI, SW, PUSH, POP, CALL and RET.

---
 rtl/mem_access_unit.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer driving the Data_mem read/write interface.
// Accepts one memory-class instruction per start. It computes the word
// address and fires a single-cycle mem_read or mem_write strobe. It then
// returns write-back, base/SP-update and return-target results to the datapath.
// All outputs are registered. Each state's action becomes visible in the
// cycle after the edge that leaves that state.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            opcode,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] pc_next,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] ra_data,
  output logic                  ra_valid,
  output logic [DATA_WIDTH-1:0] ret_target,
  output logic                  ret_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [5:0] OP_LW     = 6'b000101;
  localparam logic [5:0] OP_LW_POI = 6'b000110;
  localparam logic [5:0] OP_SW     = 6'b000111;
  localparam logic [5:0] OP_CALL   = 6'b001101;
  localparam logic [5:0] OP_RET    = 6'b001110;
  localparam logic [5:0] OP_PUSH   = 6'b001111;
  localparam logic [5:0] OP_POP    = 6'b010000;

  localparam logic [DATA_WIDTH-1:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state;
  logic [5:0]            op_q;
  logic [DATA_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] offset_q;
  logic [DATA_WIDTH-1:0] store_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] new_base_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] addr_calc;
  logic [DATA_WIDTH-1:0] new_base_calc;

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      OP_LW, OP_LW_POI, OP_SW, OP_CALL, OP_RET, OP_PUSH, OP_POP: return 1'b1;
      default:                                                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_PUSH) || (op == OP_CALL);
  endfunction

  // Address and updated base/SP arithmetic, modulo 2^DATA_WIDTH.
  // The stack grows downward with pre-decrement pushes and post-increment pops.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    addr_calc     = base_q + offset_q;
    new_base_calc = base_q + ONE;
    case (op_q)
      OP_PUSH, OP_CALL: begin
        addr_calc     = base_q - ONE;
        new_base_calc = base_q - ONE;
      end
      OP_POP, OP_RET: addr_calc = base_q;
      default: ;
    endcase
  end

  // Sequencer FSM with registered strobes, pulses and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      base_q      <= '0;
      offset_q    <= '0;
      store_q     <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      new_base_q  <= '0;
      err_q       <= 1'b0;
      mem_address <= '0;
      mem_din     <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      wb_data     <= '0;
      wb_valid    <= 1'b0;
      ra_data     <= '0;
      ra_valid    <= 1'b0;
      ret_target  <= '0;
      ret_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. The
      // defaults below are therefore overridden by later branch assignments,
      // which is how the one-cycle pulses are built.
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      wb_valid  <= 1'b0;
      ra_valid  <= 1'b0;
      ret_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            op_q     <= opcode;
            base_q   <= base;
            offset_q <= offset;
            store_q  <= store_data;
            pc_q     <= pc_next;
            busy     <= 1'b1;
            if (is_mem_op(opcode)) begin
              err_q <= 1'b0;
              state <= S_CALC;
            end else begin
              err_q <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_CALC: begin
          addr_q     <= addr_calc;
          new_base_q <= new_base_calc;
          // Only the access address is range-checked. The updated base may
          // legitimately point one past the top of memory.
          if (addr_calc[DATA_WIDTH-1:ADDR_WIDTH] != '0) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          mem_address <= addr_q;
          if (is_store(op_q)) begin
            mem_write <= 1'b1;
            mem_din   <= (op_q == OP_CALL) ? pc_q : store_q;
            state     <= S_DONE;
          end else begin
            mem_read <= 1'b1;
            state    <= S_WAIT;
          end
        end

        S_WAIT: state <= S_DONE;

        S_DONE: begin
          done  <= 1'b1;
          err   <= err_q;
          busy  <= 1'b0;
          state <= S_IDLE;
          // Data_mem presents read data only after the edge that leaves WAIT,
          // so the loaded word is sampled on the edge that leaves DONE.
          if (!err_q) begin
            case (op_q)
              OP_LW: begin
                wb_valid <= 1'b1;
                wb_data  <= mem_dout;
              end
              OP_LW_POI, OP_POP: begin
                wb_valid <= 1'b1;
                wb_data  <= mem_dout;
                ra_valid <= 1'b1;
                ra_data  <= new_base_q;
              end
              OP_PUSH, OP_CALL: begin
                ra_valid <= 1'b1;
                ra_data  <= new_base_q;
              end
              OP_RET: begin
                ret_valid  <= 1'b1;
                ret_target <= mem_dout;
                ra_valid   <= 1'b1;
                ra_data    <= new_base_q;
              end
              default: ;
            endcase
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural Data_mem model.
// The stimulus pushes the expected strobes and completions. A monitor pops
// and compares them whenever the DUT strobes memory or pulses done.
module tb_mem_access_unit;

  localparam logic [5:0] OP_ADD    = 6'b000001;
  localparam logic [5:0] OP_LW     = 6'b000101;
  localparam logic [5:0] OP_LW_POI = 6'b000110;
  localparam logic [5:0] OP_SW     = 6'b000111;
  localparam logic [5:0] OP_CALL   = 6'b001101;
  localparam logic [5:0] OP_RET    = 6'b001110;
  localparam logic [5:0] OP_PUSH   = 6'b001111;
  localparam logic [5:0] OP_POP    = 6'b010000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] base, offset, store_data, pc_next;
  logic [31:0] mem_address, mem_din, mem_dout;
  logic        mem_read, mem_write;
  logic [31:0] wb_data, ra_data, ret_target;
  logic        wb_valid, ra_valid, ret_valid, busy, done, err;

  mem_access_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .base       (base),
    .offset     (offset),
    .store_data (store_data),
    .pc_next    (pc_next),
    .mem_address(mem_address),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout),
    .wb_data    (wb_data),
    .wb_valid   (wb_valid),
    .ra_data    (ra_data),
    .ra_valid   (ra_valid),
    .ret_target (ret_target),
    .ret_valid  (ret_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          start_cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
  } strb_t;

  typedef struct {
    string       name;
    int          start_cyc;
    int          lat;
    logic        err;
    logic        wbv;
    logic [31:0] wbd;
    logic        rav;
    logic [31:0] rad;
    logic        retv;
    logic [31:0] rett;
  } resp_t;

  strb_t strb_q[$];
  resp_t resp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_count = 0;
  int wr_count = 0;

  logic [31:0] mem [1024];

  // Free-running cycle count; cycle n after the start edge reads start+n.
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous Data_mem model: write on strobe, read data after the edge.
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:0]] <= mem_din;
    if (mem_read)  mem_dout <= mem[mem_address[9:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic strb_t mk_strb(input string n, input logic w, input logic [31:0] a,
                                    input logic [31:0] d);
    strb_t s;
    s.name = n; s.start_cyc = 0; s.wr = w; s.addr = a; s.din = d;
    return s;
  endfunction

  function automatic resp_t mk_resp(input string n, input int l, input logic e,
                                    input logic wv, input logic [31:0] wd,
                                    input logic rv, input logic [31:0] rd,
                                    input logic tv, input logic [31:0] td);
    resp_t r;
    r.name = n; r.start_cyc = 0; r.lat = l; r.err = e;
    r.wbv = wv; r.wbd = wd; r.rav = rv; r.rad = rd; r.retv = tv; r.rett = td;
    return r;
  endfunction

  // Monitor: compares every strobe and completion against the queued expectations.
  always @(negedge clk) begin
    if (mem_read === 1'b1 && mem_write === 1'b1) begin
      checks++; errors++;
      $display("FAIL strobe_overlap: got read=1 write=1 expected at most one");
    end
    if (mem_read === 1'b1 || mem_write === 1'b1) begin
      if (mem_read === 1'b1) rd_count++;
      if (mem_write === 1'b1) wr_count++;
      if (strb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: got read=%b write=%b addr=%h expected none",
                 mem_read, mem_write, mem_address);
      end else begin
        strb_t s;
        s = strb_q.pop_front();
        check({s.name, "_strobe_wr"}, {31'd0, mem_write}, {31'd0, s.wr});
        check({s.name, "_strobe_lat"}, cyc - s.start_cyc, 32'd2);
        check({s.name, "_addr"}, mem_address, s.addr);
        if (s.wr) check({s.name, "_din"}, mem_din, s.din);
      end
    end
    if (done === 1'b1) begin
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        check({r.name, "_done_lat"}, cyc - r.start_cyc, r.lat);
        check({r.name, "_err"}, {31'd0, err}, {31'd0, r.err});
        check({r.name, "_wb_valid"}, {31'd0, wb_valid}, {31'd0, r.wbv});
        check({r.name, "_ra_valid"}, {31'd0, ra_valid}, {31'd0, r.rav});
        check({r.name, "_ret_valid"}, {31'd0, ret_valid}, {31'd0, r.retv});
        if (r.wbv)  check({r.name, "_wb_data"}, wb_data, r.wbd);
        if (r.rav)  check({r.name, "_ra_data"}, ra_data, r.rad);
        if (r.retv) check({r.name, "_ret_target"}, ret_target, r.rett);
      end
    end else if (wb_valid === 1'b1 || ra_valid === 1'b1 || ret_valid === 1'b1) begin
      checks++; errors++;
      $display("FAIL stray_valid: got wb=%b ra=%b ret=%b without done",
               wb_valid, ra_valid, ret_valid);
    end
  end

  // Pulses start for one cycle and queues the expected strobe and completion.
  task automatic begin_op(input logic [5:0] op, input logic [31:0] b, input logic [31:0] off,
                          input logic [31:0] sd, input logic [31:0] pc,
                          input logic has_strb, input strb_t s,
                          input logic has_resp, input resp_t r);
    @(negedge clk);
    opcode = op; base = b; offset = off; store_data = sd; pc_next = pc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s.start_cyc = cyc;
    r.start_cyc = cyc;
    if (has_strb) strb_q.push_back(s);
    if (has_resp) resp_q.push_back(r);
  endtask

  task automatic run_op(input logic [5:0] op, input logic [31:0] b, input logic [31:0] off,
                        input logic [31:0] sd, input logic [31:0] pc,
                        input logic has_strb, input strb_t s, input resp_t r);
    begin_op(op, b, off, sd, pc, has_strb, s, 1'b1, r);
    repeat (6) @(negedge clk);
  endtask

  strb_t no_s;
  int    rd_before, wr_before;

  initial begin
    no_s = mk_strb("none", 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    reset = 1'b1; start = 1'b0; opcode = '0;
    base = '0; offset = '0; store_data = '0; pc_next = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_pulses", {26'd0, mem_read, mem_write, wb_valid, ra_valid, ret_valid, done}, 32'd0);
    check("reset_data", wb_data | ra_data | ret_target | mem_address | mem_din, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(OP_SW, 32'd5, 32'd3, 32'h12345678, 32'd0, 1'b1,
           mk_strb("sw", 1'b1, 32'd8, 32'h12345678),
           mk_resp("sw", 3, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0));
    run_op(OP_LW, 32'd5, 32'd3, 32'd0, 32'd0, 1'b1,
           mk_strb("lw", 1'b0, 32'd8, 32'd0),
           mk_resp("lw", 4, 1'b0, 1'b1, 32'h12345678, 1'b0, 0, 1'b0, 0));
    run_op(OP_PUSH, 32'h100, 32'd0, 32'hA5A5A5A5, 32'd0, 1'b1,
           mk_strb("push", 1'b1, 32'hFF, 32'hA5A5A5A5),
           mk_resp("push", 3, 1'b0, 1'b0, 0, 1'b1, 32'hFF, 1'b0, 0));
    run_op(OP_POP, 32'hFF, 32'd0, 32'd0, 32'd0, 1'b1,
           mk_strb("pop", 1'b0, 32'hFF, 32'd0),
           mk_resp("pop", 4, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h100, 1'b0, 0));
    check("wb_data_hold", wb_data, 32'hA5A5A5A5);
    check("ra_data_hold", ra_data, 32'h100);
    run_op(OP_CALL, 32'h200, 32'd0, 32'hDEADBEEF, 32'h40, 1'b1,
           mk_strb("call", 1'b1, 32'h1FF, 32'h40),
           mk_resp("call", 3, 1'b0, 1'b0, 0, 1'b1, 32'h1FF, 1'b0, 0));
    run_op(OP_RET, 32'h1FF, 32'd0, 32'd0, 32'd0, 1'b1,
           mk_strb("ret", 1'b0, 32'h1FF, 32'd0),
           mk_resp("ret", 4, 1'b0, 1'b0, 0, 1'b1, 32'h200, 1'b1, 32'h40));
    run_op(OP_LW_POI, 32'h10, 32'hFFFFFFF8, 32'd0, 32'd0, 1'b1,
           mk_strb("lw_poi", 1'b0, 32'd8, 32'd0),
           mk_resp("lw_poi", 4, 1'b0, 1'b1, 32'h12345678, 1'b1, 32'h11, 1'b0, 0));
    run_op(OP_LW_POI, 32'h3FF, 32'd1, 32'd0, 32'd0, 1'b0, no_s,
           mk_resp("lw_poi_range", 2, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0));
    run_op(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, no_s,
           mk_resp("bad_opcode", 1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0));
    run_op(OP_PUSH, 32'd0, 32'd0, 32'h1, 32'd0, 1'b0, no_s,
           mk_resp("push_wrap", 2, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0));
    run_op(OP_SW, 32'h3FF, 32'd0, 32'hCAFEF00D, 32'd0, 1'b1,
           mk_strb("sw_top", 1'b1, 32'h3FF, 32'hCAFEF00D),
           mk_resp("sw_top", 3, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0));
    run_op(OP_POP, 32'h3FF, 32'd0, 32'd0, 32'd0, 1'b1,
           mk_strb("pop_top", 1'b0, 32'h3FF, 32'd0),
           mk_resp("pop_top", 4, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 32'h400, 1'b0, 0));

    // A start pulse while busy must not launch a second access.
    rd_before = rd_count;
    wr_before = wr_count;
    begin_op(OP_SW, 32'h20, 32'd0, 32'h11, 32'd0, 1'b1,
             mk_strb("sw_busy", 1'b1, 32'h20, 32'h11), 1'b1,
             mk_resp("sw_busy", 3, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0));
    @(negedge clk);
    @(negedge clk);
    opcode = OP_LW; base = 32'h30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_ignore_reads", rd_count - rd_before, 32'd0);
    check("busy_ignore_writes", wr_count - wr_before, 32'd1);

    // Reset during WAIT of a load: the strobe already went out, no completion follows.
    begin_op(OP_LW, 32'd5, 32'd3, 32'd0, 32'd0, 1'b1,
             mk_strb("lw_rst", 1'b0, 32'd8, 32'd0), 1'b0, mk_resp("x", 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_pulses", {26'd0, mem_read, mem_write, wb_valid, ra_valid, ret_valid, done}, 32'd0);
    check("rst_mid_data", wb_data | ra_data | ret_target | mem_address | mem_din, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    check("strobe_queue_drained", strb_q.size(), 32'd0);
    check("resp_queue_drained", resp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
